instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port mem_rd, output, 1 bit: byte read strobe to instruction memory.
REQ-004 SHALL have port mem_addr, output, 16 bits: byte address of the current read.
REQ-005 SHALL have port mem_rdata, input, 8 bits: returned byte, valid only when mem_rvalid is high.
REQ-006 SHALL have port mem_rvalid, input, 1 bit: read response; latency is at least 1 cycle after mem_rd; at most one read is outstanding.
REQ-007 SHALL have port fetch_req, input, 1 bit: core accepts the head instruction (driven by the core's ImRead).
REQ-008 SHALL have port redirect, input, 1 bit: one-cycle PC load (branch or jump).
REQ-009 SHALL have port redirect_pc, input, 16 bits: new fetch PC; bit 0 is forced to 0.
REQ-010 SHALL have port instr, output, 16 bits: head instruction.
REQ-011 SHALL have port instr_pc, output, 16 bits: byte address of the head instruction.
REQ-012 SHALL have port instr_valid, output, 1 bit: FIFO not empty.
REQ-013 SHALL have port fifo_count, output, 2 bits: number of occupied entries (0..2).

Function
REQ-014 SHALL implement FSM states IDLE, RD_HI, WT_HI, RD_LO, WT_LO and DRAIN.
REQ-015 SHALL assert mem_rd for exactly one cycle, in RD_HI and RD_LO only, and SHALL hold mem_rd low in all other states.
- RD_HI: mem_addr = pc.
- RD_LO: mem_addr = pc+1, computed mod 2^16.
REQ-016 SHALL order bytes big-endian: instr = {byte at pc, byte at pc+1}.
REQ-017 SHALL make these FSM transitions:
- IDLE->RD_HI when the start condition holds (REQ-029).
- RD_HI->WT_HI.
- WT_HI->RD_LO on mem_rvalid, capturing the high byte.
- RD_LO->WT_LO.
- WT_LO->IDLE on mem_rvalid: pushes {hi,lo} with instr_pc=pc, then pc <= pc+2 mod 2^16.
REQ-018 SHALL stay in the WT_* states while mem_rvalid is low, with no timeout.
REQ-019 SHALL present the FIFO as 2 entries with head at instr/instr_pc; a pop occurs when instr_valid and fetch_req are both high.
- fetch_req while empty is ignored.
REQ-020 SHALL support push and pop in the same cycle, leaving fifo_count unchanged and FIFO order preserved.
REQ-021 SHALL drive instr/instr_pc from registers; their value is don't-care while instr_valid is low.
REQ-022 SHALL handle redirect as follows (highest priority):
- FIFO is emptied; fetch_count=0 and instr_valid=0 from the next cycle.
- pc <= {redirect_pc[15:1],0}.
- Any pop in the same cycle is void.
REQ-023 SHALL, on redirect in WT_HI or WT_LO without mem_rvalid in the same cycle, enter DRAIN.
- DRAIN discards the next mem_rvalid, then goes to IDLE.
- On redirect in RD_HI or RD_LO, go to DRAIN.
- In IDLE, or in WT_* with mem_rvalid in the same cycle, go to IDLE and discard the response.
REQ-024 SHALL, on redirect while in DRAIN, update pc and remain in DRAIN.
REQ-025 SHALL wrap pc from 0xFFFE to 0x0000 without any flag.

Reset
REQ-026 SHALL, with rst high at a clock edge, set:
- state=IDLE, pc=0x0000, FIFO empty.
- mem_rd=0, mem_addr=0x0000.
- instr=0x0000, instr_pc=0x0000, instr_valid=0, fifo_count=0.
REQ-027 SHALL abandon any in-flight read on reset, and SHALL ignore any mem_rvalid in the first cycle after reset.
REQ-028 SHALL give reset priority over redirect and fetch_req.

Configuration
REQ-029 SHALL compile prefetch in or out with macro IFU_PREFETCH_EN.
- Defined: FIFO depth 2; IDLE->RD_HI whenever fifo_count<2, independent of fetch_req.
- Undefined: FIFO depth 1, fifo_count is 0 or 1, and IDLE->RD_HI only when fifo_count==0 and fetch_req==1 (demand fetch).
REQ-030 SHALL otherwise behave identically with or without IFU_PREFETCH_EN.

Verification
REQ-031 SHALL cover prefetch-defined, 1-cycle memory, bytes 0x8A,0x12 at 0x0000/0x0001, rst released at cycle 0 -> instr_valid=1 in cycle 5, instr=0x8A12, instr_pc=0x0000.
REQ-032 SHALL cover prefetch-defined, fetch_req held low -> fifo_count saturates at 2, instr_pc values 0x0000 then 0x0002, no further mem_rd.
REQ-033 SHALL cover redirect to 0x0041 while in WT_LO, response delayed 3 cycles -> DRAIN entered, stale byte dropped, next mem_addr=0x0040, fifo_count=0.
REQ-034 SHALL cover pc=0xFFFE with bytes 0x30,0x05 -> instr=0x3005, instr_pc=0xFFFE, next instr_pc=0x0000.
REQ-035 SHALL cover prefetch-undefined with fetch_req low -> mem_rd never asserted; fetch_req pulse -> exactly two mem_rd pulses, then instr_valid=1 held until fetch_req.
REQ-036 SHALL cover rst asserted in WT_HI with mem_rvalid arriving the next cycle -> all outputs zero, response ignored, fetch restarts at 0x0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Byte-wide instruction fetch: two byte reads per 16-bit big-endian instruction,
// queued in a small FIFO. Define IFU_PREFETCH_EN for 2-deep prefetch; default is 1-deep demand fetch.
//   state | meaning
//   IDLE  | no read outstanding, waiting for the start condition
//   RD_HI | strobe read of the high byte at pc
//   WT_HI | wait for the high byte
//   RD_LO | strobe read of the low byte at pc+1
//   WT_LO | wait for the low byte, then push
//   DRAIN | discard the response of a read cancelled by redirect
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  input  logic        fetch_req,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic [1:0]  fifo_count
);

  typedef enum logic [2:0] {IDLE, RD_HI, WT_HI, RD_LO, WT_LO, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] ent0_instr_q, ent0_instr_d, ent0_pc_q, ent0_pc_d;
  logic [15:0] ent1_instr_q, ent1_instr_d, ent1_pc_q, ent1_pc_d;
  logic [1:0]  count_q, count_d;
  logic        start, push, pop;
  logic [15:0] new_instr;

  always_comb begin
`ifdef IFU_PREFETCH_EN
    start = (count_q < 2'd2);
`else
    start = (count_q == 2'd0) && fetch_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hi_d         = hi_q;
    ent0_instr_d = ent0_instr_q;
    ent0_pc_d    = ent0_pc_q;
    ent1_instr_d = ent1_instr_q;
    ent1_pc_d    = ent1_pc_q;
    count_d      = count_q;
    push         = 1'b0;
    pop          = (count_q != 2'd0) && fetch_req && !redirect;
    new_instr    = {hi_q, mem_rdata};

    case (state_q)
      IDLE:  if (start) state_d = RD_HI;
      RD_HI: state_d = WT_HI;
      WT_HI: if (mem_rvalid) begin
        hi_d    = mem_rdata;
        state_d = RD_LO;
      end
      RD_LO: state_d = WT_LO;
      WT_LO: if (mem_rvalid) begin
        push    = !redirect;
        state_d = IDLE;
        pc_d    = pc_q + 16'd2;
      end
      DRAIN: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push && pop) begin
      if (count_q == 2'd2) begin
        ent0_instr_d = ent1_instr_q;
        ent0_pc_d    = ent1_pc_q;
        ent1_instr_d = new_instr;
        ent1_pc_d    = pc_q;
      end else begin
        ent0_instr_d = new_instr;
        ent0_pc_d    = pc_q;
      end
    end else if (pop) begin
      ent0_instr_d = ent1_instr_q;
      ent0_pc_d    = ent1_pc_q;
      count_d      = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        ent0_instr_d = new_instr;
        ent0_pc_d    = pc_q;
      end else begin
        ent1_instr_d = new_instr;
        ent1_pc_d    = pc_q;
      end
      count_d = count_q + 2'd1;
    end

    // A read still owed by memory must be drained; a response arriving now closes it.
    if (redirect) begin
      pc_d    = {redirect_pc[15:1], 1'b0};
      count_d = 2'd0;
      case (state_q)
        RD_HI, RD_LO:        state_d = DRAIN;
        WT_HI, WT_LO, DRAIN: state_d = mem_rvalid ? IDLE : DRAIN;
        default:             state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= 16'h0000;
      hi_q         <= 8'h00;
      ent0_instr_q <= 16'h0000;
      ent0_pc_q    <= 16'h0000;
      ent1_instr_q <= 16'h0000;
      ent1_pc_q    <= 16'h0000;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hi_q         <= hi_d;
      ent0_instr_q <= ent0_instr_d;
      ent0_pc_q    <= ent0_pc_d;
      ent1_instr_q <= ent1_instr_d;
      ent1_pc_q    <= ent1_pc_d;
      count_q      <= count_d;
    end
  end

  assign mem_rd      = (state_q == RD_HI) || (state_q == RD_LO);
  assign mem_addr    = (state_q == RD_LO) ? pc_q + 16'd1 : pc_q;
  assign instr       = ent0_instr_q;
  assign instr_pc    = ent0_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory model of programmable latency.
// Works in both builds; IFU_PREFETCH_EN selects the prefetch-specific scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        fetch_req;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [1:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .fetch_req(fetch_req),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // memory contents: fixed bytes at 0x0000/1 and 0xFFFE/F, else addr[7:0]^0xA5
  function automatic logic [7:0] mbyte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h8A;
      16'h0001: return 8'h12;
      16'hFFFE: return 8'h30;
      16'hFFFF: return 8'h05;
      default:  return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [15:0] raddr = 16'h0;
  int          rd_cnt = 0;
  logic [15:0] last_addr = 16'h0;

  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      pend      = 1'b1;
      cnt       = lat;
      raddr     = mem_addr;
      rd_cnt    = rd_cnt + 1;
      last_addr = mem_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'hEE;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mbyte(raddr);
        pend       = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n = 0;
    while (rd_cnt < target && n < 60) begin
      nxt();
      n++;
    end
    if (rd_cnt < target) chk({tag, "_timeout"}, rd_cnt, target);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      nxt();
      n++;
    end
    if (instr_valid !== 1'b1) chk({tag, "_timeout"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic fetch_one(input string tag);
    int n;
`ifndef IFU_PREFETCH_EN
    fetch_req = 1'b1;
    wait_rd(rd_cnt + 1, tag);
    fetch_req = 1'b0;
`endif
    wait_valid(tag, n);
  endtask

  task automatic pop();
    fetch_req = 1'b1;
    nxt();
    fetch_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_req = 1'b0;
    redirect = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'h0);
    chk({tag, "_instr"}, {16'd0, instr}, 32'h0);
    chk({tag, "_instr_pc"}, {16'd0, instr_pc}, 32'h0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_count"}, {30'd0, fifo_count}, 32'd0);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; fetch_req = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    mem_rvalid = 1'b0; mem_rdata = 8'hEE;
    nxt();
    nxt();
    chk_zero("reset");
    rst = 1'b0;

`ifdef IFU_PREFETCH_EN
    base = rd_cnt;
    wait_valid("pf_first", n);
    chk("pf_latency", n, 5);
    chk("pf_instr0", {16'd0, instr}, 32'h8A12);
    chk("pf_pc0", {16'd0, instr_pc}, 32'h0000);
    repeat (30) nxt();
    chk("pf_sat_count", {30'd0, fifo_count}, 32'd2);
    chk("pf_sat_pc", {16'd0, instr_pc}, 32'h0000);
    chk("pf_sat_reads", rd_cnt - base, 4);
    pop();
    chk("pf_pop_pc", {16'd0, instr_pc}, 32'h0002);
    chk("pf_pop_instr", {16'd0, instr}, 32'hA7A6);
    chk("pf_pop_count", {30'd0, fifo_count}, 32'd1);
`else
    base = rd_cnt;
    repeat (10) nxt();
    chk("dm_idle_reads", rd_cnt - base, 0);
    fetch_req = 1'b1;
    n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      nxt();
      n++;
      if (n == 1) fetch_req = 1'b0;
    end
    chk("dm_latency", n, 5);
    chk("dm_instr0", {16'd0, instr}, 32'h8A12);
    chk("dm_pc0", {16'd0, instr_pc}, 32'h0000);
    chk("dm_count0", {30'd0, fifo_count}, 32'd1);
    repeat (10) nxt();
    chk("dm_hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("dm_two_reads", rd_cnt - base, 2);
    pop();
    chk("dm_pop_valid", {31'd0, instr_valid}, 32'd0);
    chk("dm_pop_count", {30'd0, fifo_count}, 32'd0);
    repeat (5) nxt();
    chk("dm_no_refetch", rd_cnt - base, 2);
    fetch_one("dm_second");
    chk("dm_instr1", {16'd0, instr}, 32'hA7A6);
    chk("dm_pc1", {16'd0, instr_pc}, 32'h0002);
`endif

    // redirect while waiting for the low byte
    do_reset();
    base = rd_cnt;
    lat = 3;
`ifndef IFU_PREFETCH_EN
    fetch_req = 1'b1;
    wait_rd(base + 1, "rdr_hi");
    fetch_req = 1'b0;
`endif
    wait_rd(base + 2, "rdr_lo");
    lat = 1;
    nxt();
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    nxt();
    redirect = 1'b0;
`ifndef IFU_PREFETCH_EN
    fetch_req = 1'b1;
`endif
    chk("rdr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rdr_count", {30'd0, fifo_count}, 32'd0);
    nxt();
    nxt();
    chk("rdr_drain_no_rd", rd_cnt - base, 2);
    wait_rd(base + 3, "rdr_new");
    fetch_req = 1'b0;
    chk("rdr_addr", {16'd0, last_addr}, 32'h0040);
    wait_valid("rdr_fill", n);
    chk("rdr_instr", {16'd0, instr}, 32'hE5E4);
    chk("rdr_pc", {16'd0, instr_pc}, 32'h0040);

    // wrap at the top of the address space; bit 0 of redirect_pc is dropped
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    nxt();
    redirect = 1'b0;
    fetch_one("wrap_a");
    chk("wrap_instr", {16'd0, instr}, 32'h3005);
    chk("wrap_pc", {16'd0, instr_pc}, 32'hFFFE);
    pop();
    fetch_one("wrap_b");
    chk("wrap_next_pc", {16'd0, instr_pc}, 32'h0000);
    chk("wrap_next_instr", {16'd0, instr}, 32'h8A12);

    // reset while waiting for a high byte at pc=2, response lands just after reset
    do_reset();
    base = rd_cnt;
`ifdef IFU_PREFETCH_EN
    wait_rd(base + 2, "rst_lo0");
    lat = 2;
    wait_rd(base + 3, "rst_hi1");
`else
    fetch_one("rst_pre");
    pop();
    lat = 2;
    fetch_req = 1'b1;
    wait_rd(base + 3, "rst_hi1");
    fetch_req = 1'b0;
`endif
    chk("rst_inflight_addr", {16'd0, last_addr}, 32'h0002);
    lat = 1;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk_zero("rst_wt");
`ifndef IFU_PREFETCH_EN
    fetch_req = 1'b1;
`endif
    wait_rd(base + 4, "rst_restart");
    fetch_req = 1'b0;
    chk("rst_restart_addr", {16'd0, last_addr}, 32'h0000);
    wait_valid("rst_fill", n);
    chk("rst_instr", {16'd0, instr}, 32'h8A12);
    chk("rst_pc", {16'd0, instr_pc}, 32'h0000);

    // reset wins over redirect and fetch_req
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h1234;
    fetch_req = 1'b1;
    nxt();
    nxt();
    chk_zero("rst_prio");
    rst = 1'b0;
    redirect = 1'b0;
`ifdef IFU_PREFETCH_EN
    fetch_req = 1'b0;
`endif
    base = rd_cnt;
    wait_rd(base + 1, "prio_rd");
    fetch_req = 1'b0;
    chk("prio_addr", {16'd0, last_addr}, 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
